// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: queue entry layout, JAL decode helpers
// and reset constants.
package instruction_fetcher_pkg;

   localparam logic [6:0]  OPCODE_JAL       = 7'b1101111;
   localparam int          IQ_DEPTH_DEFAULT = 8;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   // last_req_pc value that can never equal a fetch PC, so nothing is accepted before the first request
   localparam logic [31:0] NO_REQ_PC        = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        compressed;
   } iq_entry_t;

   function automatic logic is_jal(input logic [31:0] inst);
      return inst[6:0] == OPCODE_JAL;
   endfunction

   // J-type immediate: imm[20|10:1|11|19:12] sits in inst[31|30:21|20|19:12]
   function automatic logic [31:0] jal_imm(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/instruction_fetcher_queue.sv
// In-order instruction queue: power-of-two ring buffer with push, pop, clear and a
// combinational head view that reads as zero while empty.
module inst_queue
   import instruction_fetcher_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      en_i,
   input  logic      push_i,
   input  logic      pop_i,
   input  logic      clear_i,
   input  iq_entry_t data_i,
   output iq_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   iq_entry_t     mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = en_i & push_i & ~full_o & ~clear_i;
   assign do_pop  = en_i & pop_i & ~empty_o & ~clear_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (en_i && clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + AW'(1);
         if (do_pop)  head_d = head_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; stale slots are hidden by the empty gating on head_o
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[tail_q] <= data_i;
   end

   assign head_o = empty_o ? '0 : mem_q[head_q];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch-PC owner between the instruction cache and the decoder: accepts cache hits
// into the instruction queue, follows JAL statically and redirects on back-end flush.
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int          IQ_DEPTH = IQ_DEPTH_DEFAULT,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic [31:0] ic_req_pc,
   input  logic [31:0] ic_inst_in,
   input  logic        ic_valid_in,
   input  logic        ic_compressed_in,
   input  logic        flush_in,
   input  logic [31:0] flush_pc_in,
   input  logic        dec_ready_in,
   output logic        dec_valid_out,
   output logic [31:0] dec_inst_out,
   output logic [31:0] dec_pc_out,
   output logic        dec_compressed_out
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] last_req_pc_q, last_req_pc_d;
   logic [31:0] next_pc;
   logic        iq_full;
   logic        iq_empty;
   logic        accept;
   logic        pop;
   iq_entry_t   push_entry;
   iq_entry_t   head_entry;

   assign next_pc = is_jal(ic_inst_in) ? pc_q + jal_imm(ic_inst_in)
                                       : pc_q + (ic_compressed_in ? 32'd2 : 32'd4);

   // Response only counts if it answers the PC we are still waiting on
   assign accept = rdy_in & ic_valid_in & (last_req_pc_q == pc_q) & ~iq_full & ~flush_in;
   assign pop    = rdy_in & dec_valid_out & dec_ready_in & ~flush_in;

   // Requesting next_pc in the accept cycle keeps one fetch per cycle on hits
   assign ic_req_pc     = flush_in ? flush_pc_in : (accept ? next_pc : pc_q);
   assign pc_d          = ic_req_pc;
   assign last_req_pc_d = ic_req_pc;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc_q          <= RESET_PC;
         last_req_pc_q <= NO_REQ_PC;
      end else if (rdy_in) begin
         pc_q          <= pc_d;
         last_req_pc_q <= last_req_pc_d;
      end
   end

   assign push_entry = '{inst: ic_inst_in, pc: pc_q, compressed: ic_compressed_in};

   inst_queue #(
      .DEPTH (IQ_DEPTH)
   ) u_queue (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .en_i    (rdy_in),
      .push_i  (accept),
      .pop_i   (pop),
      .clear_i (flush_in),
      .data_i  (push_entry),
      .head_o  (head_entry),
      .full_o  (iq_full),
      .empty_o (iq_empty)
   );

   assign dec_valid_out      = ~iq_empty;
   assign dec_inst_out       = head_entry.inst;
   assign dec_pc_out         = head_entry.pc;
   assign dec_compressed_out = head_entry.compressed;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomised bench: a behavioural cache + program-trace model predicts the exact
// in-order stream of (pc, inst, compressed) the decoder must see.
module tb_instruction_fetcher;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] ic_req_pc;
   logic [31:0] ic_inst_in;
   logic        ic_valid_in;
   logic        ic_compressed_in;
   logic        flush_in;
   logic [31:0] flush_pc_in;
   logic        dec_ready_in;
   logic        dec_valid_out;
   logic [31:0] dec_inst_out;
   logic [31:0] dec_pc_out;
   logic        dec_compressed_out;

   instruction_fetcher #(.IQ_DEPTH(8), .RESET_PC(32'h0)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .rdy_in             (rdy_in),
      .ic_req_pc          (ic_req_pc),
      .ic_inst_in         (ic_inst_in),
      .ic_valid_in        (ic_valid_in),
      .ic_compressed_in   (ic_compressed_in),
      .flush_in           (flush_in),
      .flush_pc_in        (flush_pc_in),
      .dec_ready_in       (dec_ready_in),
      .dec_valid_out      (dec_valid_out),
      .dec_inst_out       (dec_inst_out),
      .dec_pc_out         (dec_pc_out),
      .dec_compressed_out (dec_compressed_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        comp;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   int          pops     = 0;
   exp_t        exp_q[$];
   logic [31:0] prog_inst [256];
   logic        prog_comp [256];
   logic        prog_jal  [256];
   int          prog_imm  [256];
   logic [31:0] req_last;
   bit          mon_en = 1'b0;

   // monitor history for hold checks across rdy_in=0 edges
   bit          have_prev = 1'b0;
   logic        prev_rdy, prev_flush;
   logic [95:0] prev_dec;
   logic [31:0] prev_req;

   function automatic int idx(input logic [31:0] pc);
      return int'(pc[8:1]);
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Architectural program order from start; the decoder must see exactly this sequence
   task automatic load_trace(input logic [31:0] start);
      logic [31:0] pc;
      int          i;
      exp_q.delete();
      pc = start;
      for (int n = 0; n < 64; n++) begin
         i = idx(pc);
         exp_q.push_back('{pc: pc, inst: prog_inst[i], comp: prog_comp[i]});
         pc = prog_jal[i] ? pc + 32'(prog_imm[i]) : pc + (prog_comp[i] ? 32'd2 : 32'd4);
      end
   endtask

   task automatic set_plain(input int i, input logic comp);
      logic [31:0] rnd;
      rnd          = $urandom();
      prog_inst[i] = {rnd[31:7], 7'b0010011};
      prog_comp[i] = comp;
      prog_jal[i]  = 1'b0;
      prog_imm[i]  = 0;
   endtask

   task automatic set_jal(input int i, input int imm, input logic comp);
      logic [20:0] im;
      logic [4:0]  rd;
      im           = 21'(imm);
      rd           = 5'($urandom_range(0, 31));
      prog_inst[i] = {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
      prog_comp[i] = comp;
      prog_jal[i]  = 1'b1;
      prog_imm[i]  = imm;
   endtask

   task automatic build_program();
      logic [31:0] rnd;
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 99) < 15) begin
            set_jal(i, (int'($urandom_range(0, 64)) - 32) * 2, 1'($urandom_range(0, 1)));
         end else begin
            rnd = $urandom();
            prog_inst[i] = {rnd[31:7], ($urandom_range(0, 1) != 0) ? 7'b0010011 : 7'b1100011};
            prog_comp[i] = 1'($urandom_range(0, 1));
            prog_jal[i]  = 1'b0;
            prog_imm[i]  = 0;
         end
      end
      set_plain(0, 1'b1);
      set_plain(1, 1'b1);
      for (int i = 2; i < 8; i++) set_plain(i, 1'b0);
      set_jal(8, 32'h100, 1'b0);     // pc 0x10
      set_plain(12, 1'b0);           // pc 0x18
      set_plain(14, 1'b0);           // pc 0x1C
      set_jal(16, -8, 1'b0);         // pc 0x20
   endtask

   // One clock of cache + back-end stimulus; cache answers the PC requested last cycle
   task automatic drive_cycle(input bit valid, input bit ready, input bit rdy,
                              input bit flush, input logic [31:0] fpc,
                              output logic [31:0] req_seen);
      rdy_in       = rdy;
      ic_valid_in  = valid;
      dec_ready_in = ready;
      flush_in     = flush;
      flush_pc_in  = fpc;
      if (!valid) begin
         ic_inst_in       = $urandom();
         ic_compressed_in = 1'($urandom_range(0, 1));
      end else if (req_last == 32'hFFFF_FFFF) begin
         ic_inst_in       = 32'h1000_006F;
         ic_compressed_in = 1'b0;
      end else begin
         ic_inst_in       = prog_inst[idx(req_last)];
         ic_compressed_in = prog_comp[idx(req_last)];
      end
      if (flush && rdy) load_trace(fpc);
      @(negedge clk_in);
      req_seen = ic_req_pc;
      @(posedge clk_in);
      if (rdy) req_last = req_seen;
      #1;
   endtask

   always @(negedge clk_in) begin
      if (!mon_en || rst_in) begin
         have_prev = 1'b0;
      end else begin
         if (!dec_valid_out)
            check("idle_outputs_zero",
                  {dec_inst_out, dec_pc_out, 31'b0, dec_compressed_out}, 96'b0);
         if (have_prev && !prev_rdy)
            check("rdy_hold_outputs",
                  {dec_inst_out, dec_pc_out, 31'b0, dec_compressed_out}, prev_dec);
         if (have_prev && !prev_rdy && !prev_flush && !rdy_in && !flush_in)
            check("rdy_hold_req_pc", {64'b0, ic_req_pc}, {64'b0, prev_req});
         if (flush_in)
            check("flush_req_pc", {64'b0, ic_req_pc}, {64'b0, flush_pc_in});
         if (rdy_in && dec_valid_out && dec_ready_in && !flush_in) begin
            exp_t e;
            pops++;
            if (exp_q.size() == 0) begin
               check("trace_exhausted", {dec_inst_out, dec_pc_out, 32'b0}, 96'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               $display("pop pc=%h inst=%h c=%0d expected pc=%h inst=%h c=%0d",
                        dec_pc_out, dec_inst_out, dec_compressed_out, e.pc, e.inst, e.comp);
               check("pop_entry", {dec_pc_out, dec_inst_out, 31'b0, dec_compressed_out},
                     {e.pc, e.inst, 31'b0, e.comp});
            end
         end
         have_prev  = 1'b1;
         prev_rdy   = rdy_in;
         prev_flush = flush_in;
         prev_dec   = {dec_inst_out, dec_pc_out, 31'b0, dec_compressed_out};
         prev_req   = ic_req_pc;
      end
   end

   initial begin
      logic [31:0] req, req_a;
      int          since_flush;
      bit          fl, rd;

      rst_in = 1'b1; rdy_in = 1'b0; ic_valid_in = 1'b0; ic_inst_in = '0;
      ic_compressed_in = 1'b0; flush_in = 1'b0; flush_pc_in = '0; dec_ready_in = 1'b0;
      req_last = 32'hFFFF_FFFF;
      build_program();
      load_trace(32'h0);
      #12;
      check("reset_dec_outputs",
            {dec_inst_out, dec_pc_out, 30'b0, dec_valid_out, dec_compressed_out}, 96'b0);
      check("reset_req_pc", {64'b0, ic_req_pc}, 96'h0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      mon_en = 1'b1;

      // streaming hits: compressed pair, sequential words, JAL +0x100
      for (int c = 0; c < 40; c++) drive_cycle(1, 1, 1, 0, 32'h0, req);
      // JAL -8 loop at 0x20
      drive_cycle(1, 1, 1, 1, 32'h20, req);
      for (int c = 0; c < 10; c++) drive_cycle(1, 1, 1, 0, 32'h0, req);

      // fill to capacity with the decoder stalled
      drive_cycle(1, 0, 1, 1, 32'h40, req);
      pops = 0;
      for (int c = 0; c < 12; c++) drive_cycle(1, 0, 1, 0, 32'h0, req_a);
      for (int c = 0; c < 2; c++) drive_cycle(1, 0, 1, 0, 32'h0, req);
      check("stall_pc_held", {64'b0, req}, {64'b0, req_a});
      drive_cycle(1, 1, 1, 0, 32'h0, req);            // pop while full: push blocked
      for (int c = 0; c < 12; c++) drive_cycle(0, 1, 1, 0, 32'h0, req);
      check("full_entry_count", 96'(pops), 96'd8);
      check("drained_valid", {95'b0, dec_valid_out}, 96'b0);

      // flush with 5 entries queued
      drive_cycle(1, 0, 1, 1, 32'h100, req);
      for (int c = 0; c < 5; c++) drive_cycle(1, 0, 1, 0, 32'h0, req);
      check("five_queued_valid", {95'b0, dec_valid_out}, 96'b1);
      drive_cycle(1, 1, 1, 1, 32'h200, req);
      check("flush_clears_queue", {95'b0, dec_valid_out}, 96'b0);
      for (int c = 0; c < 4; c++) drive_cycle(1, 1, 1, 0, 32'h0, req);

      // global stall for 3 cycles mid-stream
      for (int c = 0; c < 3; c++) drive_cycle(1, 1, 0, 0, 32'h0, req);
      for (int c = 0; c < 4; c++) drive_cycle(1, 1, 1, 0, 32'h0, req);

      // randomised traffic
      since_flush = 40;
      for (int c = 0; c < 600; c++) begin
         fl = ($urandom_range(0, 99) < 4) || (since_flush >= 40);
         rd = fl || ($urandom_range(0, 99) < 85);
         drive_cycle($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70, rd, fl,
                     32'($urandom_range(0, 511)) & ~32'h1, req);
         since_flush = fl ? 0 : since_flush + 1;
      end

      // asynchronous reset in the middle of a stream
      drive_cycle(1, 0, 1, 1, 32'h80, req);
      for (int c = 0; c < 6; c++) drive_cycle(1, 0, 1, 0, 32'h0, req);
      @(negedge clk_in); #2;
      mon_en = 1'b0;
      flush_in = 1'b0;
      rst_in = 1'b1;
      #1;
      check("async_reset_valid", {95'b0, dec_valid_out}, 96'b0);
      check("async_reset_req_pc", {64'b0, ic_req_pc}, 96'h0);
      req_last = 32'hFFFF_FFFF;
      load_trace(32'h0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      mon_en = 1'b1;
      for (int c = 0; c < 30; c++) drive_cycle(1, 1, 1, 0, 32'h0, req);
      for (int c = 0; c < 30; c++) drive_cycle(0, 1, 1, 0, 32'h0, req);
      check("final_drained", {95'b0, dec_valid_out}, 96'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
